mc_ctrl: RTL and testbench

- Multi-cycle main controller for the MIPS-lite datapath. It sequences fetch/decode/execute/memory/writeback over one shared ALU and one shared memory port.
- It drives the two-bit ALU op code (aluop1/aluop0) into the existing ALU-control decoder, and drives all mux selects and write enables.
- Memory accesses use a ready handshake, so slow memory stalls the FSM.

---
 rtl/mc_ctrl_if.sv | 45 ++++
 rtl/mc_ctrl.sv | 159 +++++++++++++++
 tb/tb_mc_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: bundle between the multi-cycle main controller and the datapath.
//   opcode, mem_ready          : datapath -> controller (IR opcode field, memory done)
//   aluop1/aluop0              : ALU op class to the ALU-control decoder
//   alusrca, alusrcb           : ALU operand selects
//   iord, memread, memwrite    : shared memory port address select and requests
//   irwrite, pcwrite,
//   pcwritecond, pcsource      : instruction register and PC update controls
//   regdst, memtoreg, regwrite : register-file write controls
//   illegal                    : one-cycle pulse on an undefined opcode
//   state                      : current FSM state code for debug
// Modport master is the controller side, slave is the datapath side.
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       aluop1;
  logic       aluop0;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       pcwrite;
  logic       pcwritecond;
  logic [1:0] pcsource;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output aluop1, aluop0, alusrca, alusrcb, iord, memread, memwrite,
           irwrite, pcwrite, pcwritecond, pcsource, regdst, memtoreg,
           regwrite, illegal, state
  );

  modport slave (
    output opcode, mem_ready,
    input  aluop1, aluop0, alusrca, alusrcb, iord, memread, memwrite,
           irwrite, pcwrite, pcwritecond, pcsource, regdst, memtoreg,
           regwrite, illegal, state
  );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller for the MIPS-lite datapath.
// Sequences fetch/decode/execute/memory/writeback over one shared ALU and one
// shared memory port; memory accesses stall on mem_ready.
// Ports:
//   clk   : single clock, all state changes on the rising edge
//   reset : synchronous, active-high; forces FETCH and overrides any transition
//   bus   : mc_ctrl_if.master (opcode/mem_ready in, all controls + state out)
//
// state  | meaning
// -------+--------------------------------------------------------------
// FETCH  | read instruction at PC, PC+4; waits for mem_ready
// DECODE | register read, branch target into ALUOut, dispatch on opcode
// MEMADR | effective address = A + sign-ext imm
// MEMRD  | load data read at ALUOut; waits for mem_ready
// MEMWB  | write MDR to rt
// MEMWR  | store B to ALUOut; waits for mem_ready
// EXEC   | R-type ALU operation A op B
// RWB    | write ALUOut to rd
// BRANCH | compare A-B, PC <= ALUOut if zero
// JUMP   | PC <= jump target
// ADDIEX | A + sign-ext imm
// ADDIWB | write ALUOut to rt
module mc_ctrl (
  input  logic      clk,
  input  logic      reset,
  mc_ctrl_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  // Moore controls. pcwrite here is only the unconditional load from JUMP;
  // the FETCH PC load depends on mem_ready and is added combinationally.
  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       pcwrite;
    logic       pcwritecond;
    logic [1:0] pcsource;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
  } ctrl_t;

  state_t st;
  ctrl_t  ctrl;

  function automatic logic legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

  function automatic ctrl_t moore_out(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:  begin c.memread = 1'b1; c.alusrcb = 2'b01; end
      DECODE: c.alusrcb = 2'b11;
      MEMADR: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      MEMRD:  begin c.memread = 1'b1; c.iord = 1'b1; end
      MEMWB:  begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      MEMWR:  begin c.memwrite = 1'b1; c.iord = 1'b1; end
      EXEC:   begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      RWB:    begin c.regwrite = 1'b1; c.regdst = 1'b1; end
      BRANCH: begin
        c.alusrca     = 1'b1;
        c.aluop       = 2'b01;
        c.pcwritecond = 1'b1;
        c.pcsource    = 2'b01;
      end
      JUMP:   begin c.pcwrite = 1'b1; c.pcsource = 2'b10; end
      ADDIEX: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      ADDIWB: c.regwrite = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic state_t next_of(input state_t s, input logic [5:0] op,
                                     input logic rdy);
    state_t n;
    n = FETCH;
    case (s)
      FETCH:  n = rdy ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: n = MEMADR;
          OP_RTYPE:     n = EXEC;
          OP_BEQ:       n = BRANCH;
          OP_J:         n = JUMP;
          OP_ADDI:      n = ADDIEX;
          default:      n = FETCH;
        endcase
      end
      MEMADR: n = (op == OP_SW) ? MEMWR : ((op == OP_LW) ? MEMRD : FETCH);
      MEMRD:  n = rdy ? MEMWB : MEMRD;
      MEMWR:  n = rdy ? FETCH : MEMWR;
      EXEC:   n = RWB;
      ADDIEX: n = ADDIWB;
      default: n = FETCH;
    endcase
    return n;
  endfunction

  // Controls are registered alongside the state by decoding the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      st   <= FETCH;
      ctrl <= moore_out(FETCH);
    end else begin
      st   <= next_of(st, bus.opcode, bus.mem_ready);
      ctrl <= moore_out(next_of(st, bus.opcode, bus.mem_ready));
    end
  end

  logic fetch_done;
  assign fetch_done = (st == FETCH) && bus.mem_ready;

  assign bus.aluop1      = ctrl.aluop[1];
  assign bus.aluop0      = ctrl.aluop[0];
  assign bus.alusrca     = ctrl.alusrca;
  assign bus.alusrcb     = ctrl.alusrcb;
  assign bus.iord        = ctrl.iord;
  assign bus.memread     = ctrl.memread;
  assign bus.memwrite    = ctrl.memwrite;
  assign bus.irwrite     = fetch_done;
  assign bus.pcwrite     = ctrl.pcwrite | fetch_done;
  assign bus.pcwritecond = ctrl.pcwritecond;
  assign bus.pcsource    = ctrl.pcsource;
  assign bus.regdst      = ctrl.regdst;
  assign bus.memtoreg    = ctrl.memtoreg;
  assign bus.regwrite    = ctrl.regwrite;
  assign bus.illegal     = (st == DECODE) && !legal_op(bus.opcode);
  assign bus.state       = st;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed cycle table plus randomized instruction stream for mc_ctrl.
module tb_mc_ctrl;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  logic clk = 1'b0;
  logic reset;
  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       mr;
    logic [3:0] st;
  } vec_t;

  vec_t tbl[$];
  vec_t stream[$];

  function automatic vec_t v(input logic r, input logic [5:0] op,
                             input logic mr, input logic [3:0] st);
    vec_t x;
    x.rst = r; x.op = op; x.mr = mr; x.st = st;
    return x;
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  endfunction

  // Expected outputs for a cycle spent in state s, straight from the per-state
  // output list. Packing: aluop, alusrca, alusrcb, iord, memread, memwrite,
  // irwrite, pcwrite, pcwritecond, pcsource, regdst, memtoreg, regwrite, illegal.
  function automatic logic [16:0] exp_out(input logic [3:0] s, input logic mr,
                                          input logic [5:0] op);
    logic [1:0] aluop, srcb, psrc;
    logic srca, iord, mrd, mwr, irw, pcw, pcwc, rdst, m2r, rw, ill;
    aluop = 2'b00; srcb = 2'b00; psrc = 2'b00;
    srca = 0; iord = 0; mrd = 0; mwr = 0; irw = 0; pcw = 0; pcwc = 0;
    rdst = 0; m2r = 0; rw = 0; ill = 0;
    case (s)
      4'd0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      4'd1:  begin srcb = 2'b11; ill = !is_legal(op); end
      4'd2:  begin srca = 1; srcb = 2'b10; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mwr = 1; iord = 1; end
      4'd6:  begin srca = 1; aluop = 2'b10; end
      4'd7:  begin rw = 1; rdst = 1; end
      4'd8:  begin srca = 1; aluop = 2'b01; pcwc = 1; psrc = 2'b01; end
      4'd9:  begin pcw = 1; psrc = 2'b10; end
      4'd10: begin srca = 1; srcb = 2'b10; end
      4'd11: rw = 1;
      default: ;
    endcase
    return {aluop, srca, srcb, iord, mrd, mwr, irw, pcw, pcwc, psrc, rdst, m2r, rw, ill};
  endfunction

  function automatic logic [16:0] act_out();
    return {bus.aluop1, bus.aluop0, bus.alusrca, bus.alusrcb, bus.iord,
            bus.memread, bus.memwrite, bus.irwrite, bus.pcwrite,
            bus.pcwritecond, bus.pcsource, bus.regdst, bus.memtoreg,
            bus.regwrite, bus.illegal};
  endfunction

  // One clock cycle: drive inputs after the falling edge, check the state the
  // DUT is in and its outputs, then let the rising edge happen.
  task automatic run_cycle(input vec_t x, input string tag, input int idx);
    logic [16:0] e;
    logic [16:0] a;
    @(negedge clk);
    reset         = x.rst;
    bus.opcode    = x.op;
    bus.mem_ready = x.mr;
    #1;
    checks++;
    if (bus.state !== x.st) begin
      errors++;
      $display("FAIL %s[%0d] state: got %0d expected %0d", tag, idx, bus.state, x.st);
    end
    e = exp_out(x.st, x.mr, x.op);
    a = act_out();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s[%0d] outputs (state %0d op %b rdy %0b): got %b expected %b",
               tag, idx, x.st, x.op, x.mr, a, e);
    end
  endtask

  // Reference: cycle-by-cycle state path of one instruction from its class and
  // the number of not-ready cycles seen in fetch and in the memory stage.
  task automatic build_instr(input logic [5:0] op, input int wf, input int wm);
    for (int i = 0; i < wf; i++) stream.push_back(v(0, op, 1'b0, 4'd0));
    stream.push_back(v(0, op, 1'b1, 4'd0));
    stream.push_back(v(0, op, 1'($urandom_range(0, 1)), 4'd1));
    case (op)
      OP_LW: begin
        stream.push_back(v(0, op, 1'($urandom_range(0, 1)), 4'd2));
        for (int i = 0; i < wm; i++) stream.push_back(v(0, op, 1'b0, 4'd3));
        stream.push_back(v(0, op, 1'b1, 4'd3));
        stream.push_back(v(0, op, 1'($urandom_range(0, 1)), 4'd4));
      end
      OP_SW: begin
        stream.push_back(v(0, op, 1'($urandom_range(0, 1)), 4'd2));
        for (int i = 0; i < wm; i++) stream.push_back(v(0, op, 1'b0, 4'd5));
        stream.push_back(v(0, op, 1'b1, 4'd5));
      end
      OP_RTYPE: begin
        stream.push_back(v(0, op, 1'($urandom_range(0, 1)), 4'd6));
        stream.push_back(v(0, op, 1'($urandom_range(0, 1)), 4'd7));
      end
      OP_BEQ:  stream.push_back(v(0, op, 1'($urandom_range(0, 1)), 4'd8));
      OP_J:    stream.push_back(v(0, op, 1'($urandom_range(0, 1)), 4'd9));
      OP_ADDI: begin
        stream.push_back(v(0, op, 1'($urandom_range(0, 1)), 4'd10));
        stream.push_back(v(0, op, 1'($urandom_range(0, 1)), 4'd11));
      end
      default: ;
    endcase
  endtask

  initial begin
    logic [5:0] ops[6];
    logic [5:0] op;
    reset = 1'b1;
    bus.opcode = OP_RTYPE;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    // SW with two fetch wait cycles (first row also checks the reset state)
    tbl.push_back(v(0, OP_SW, 0, 0)); tbl.push_back(v(0, OP_SW, 0, 0));
    tbl.push_back(v(0, OP_SW, 1, 0)); tbl.push_back(v(0, OP_SW, 1, 1));
    tbl.push_back(v(0, OP_SW, 1, 2)); tbl.push_back(v(0, OP_SW, 1, 5));
    // R-type, zero waits
    tbl.push_back(v(0, OP_RTYPE, 1, 0)); tbl.push_back(v(0, OP_RTYPE, 1, 1));
    tbl.push_back(v(0, OP_RTYPE, 1, 6)); tbl.push_back(v(0, OP_RTYPE, 1, 7));
    // LW with three wait cycles in MEMRD
    tbl.push_back(v(0, OP_LW, 1, 0)); tbl.push_back(v(0, OP_LW, 1, 1));
    tbl.push_back(v(0, OP_LW, 1, 2)); tbl.push_back(v(0, OP_LW, 0, 3));
    tbl.push_back(v(0, OP_LW, 0, 3)); tbl.push_back(v(0, OP_LW, 0, 3));
    tbl.push_back(v(0, OP_LW, 1, 3)); tbl.push_back(v(0, OP_LW, 1, 4));
    // BEQ then J
    tbl.push_back(v(0, OP_BEQ, 1, 0)); tbl.push_back(v(0, OP_BEQ, 1, 1));
    tbl.push_back(v(0, OP_BEQ, 1, 8));
    tbl.push_back(v(0, OP_J, 1, 0)); tbl.push_back(v(0, OP_J, 1, 1));
    tbl.push_back(v(0, OP_J, 1, 9));
    // undefined opcode, then ADDI
    tbl.push_back(v(0, OP_BAD, 1, 0)); tbl.push_back(v(0, OP_BAD, 1, 1));
    tbl.push_back(v(0, OP_ADDI, 1, 0)); tbl.push_back(v(0, OP_ADDI, 1, 1));
    tbl.push_back(v(0, OP_ADDI, 1, 10)); tbl.push_back(v(0, OP_ADDI, 1, 11));
    // reset during a MEMRD wait, then a full LW
    tbl.push_back(v(0, OP_LW, 1, 0)); tbl.push_back(v(0, OP_LW, 0, 1));
    tbl.push_back(v(0, OP_LW, 1, 2)); tbl.push_back(v(0, OP_LW, 0, 3));
    tbl.push_back(v(1, OP_LW, 0, 3)); tbl.push_back(v(0, OP_LW, 1, 0));
    tbl.push_back(v(0, OP_LW, 1, 1)); tbl.push_back(v(0, OP_LW, 1, 2));
    tbl.push_back(v(0, OP_LW, 1, 3)); tbl.push_back(v(0, OP_LW, 1, 4));
    // reset overrides FETCH->DECODE; mem_ready ignored outside memory states
    tbl.push_back(v(1, OP_RTYPE, 1, 0)); tbl.push_back(v(0, OP_RTYPE, 1, 0));
    tbl.push_back(v(0, OP_RTYPE, 0, 1)); tbl.push_back(v(0, OP_RTYPE, 0, 6));
    tbl.push_back(v(0, OP_RTYPE, 0, 7));

    for (int i = 0; i < tbl.size(); i++) run_cycle(tbl[i], "dir", i);

    ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 6) == 6) op = 6'($urandom_range(0, 63));
      else op = ops[$urandom_range(0, 5)];
      build_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    for (int i = 0; i < stream.size(); i++) run_cycle(stream[i], "rnd", i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
